// File: rtl/serial_sub_unit.sv
// ---------------------------------------------------------------------------------------------
// serial_sub_unit
//
// Bit-serial subtractor that recovers one operand of an N-bit addition from the (N+1)-bit sum
// and the other operand: diff = sum - addend, one bit per clock, LSB first. It uses a single
// full-subtractor cell plus shift registers and a start/ready/done handshake.
//
// Parameters
//   N       operand width (N >= 1); the minuend is N+1 bits wide.
//
// Ports
//   clk     input   clock, all state changes on the rising edge
//   rst_n   input   synchronous active-low reset
//   start   input   request a subtraction, sampled only while ready=1
//   sum     input   [N:0]   minuend, captured on the accepted start edge
//   addend  input   [N-1:0] subtrahend (zero-extended), captured on the accepted start edge
//   ready   output  high while idle
//   done    output  one-cycle pulse when diff/borrow/ovf are updated
//   diff    output  [N-1:0] low N bits of the (N+1)-bit difference
//   borrow  output  final borrow out of bit N (sum < addend)
//   ovf     output  no borrow but bit N of the difference is set (result >= 2^N)
//
// Build option
//   SERIAL_SUB_SAT_EN  when defined, diff saturates on the done edge: 0 on borrow, all ones on
//                      ovf. borrow/ovf still report the condition. Timing is unchanged.
//
// Latency: start accepted at edge E0, bits 0..N processed at E1..E(N+1), done visible after
// E(N+1), ready back after E(N+2). One result every N+3 cycles with start held high.
// ---------------------------------------------------------------------------------------------

module serial_sub_unit #(
    parameter int unsigned N = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [N:0]   sum,
    input  logic [N-1:0] addend,
    output logic         ready,
    output logic         done,
    output logic [N-1:0] diff,
    output logic         borrow,
    output logic         ovf
);

    // Counter must hold 0..N.
    localparam int unsigned CntW = $clog2(N + 1);
    localparam logic [CntW-1:0] LastBit = CntW'(N);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    state_e          state_q;
    logic [N:0]      min_q;    // minuend shift register, LSB is the current bit
    logic [N:0]      sub_q;    // zero-extended subtrahend shift register
    logic [N-1:0]    res_q;    // upper N bits of the partial result; new bits enter at the MSB
    logic            brw_q;    // running borrow between bit positions
    logic [CntW-1:0] cnt_q;

    // Single full-subtractor cell and the result as it stands after this edge's shift.
    logic         s_bit;
    logic         a_bit;
    logic         d_bit;
    logic         b_next;
    logic [N:0]   res_next;
    logic [N-1:0] diff_next;

    always_comb begin
        s_bit     = min_q[0];
        a_bit     = sub_q[0];
        d_bit     = s_bit ^ a_bit ^ brw_q;
        b_next    = (~s_bit & a_bit) | (~(s_bit ^ a_bit) & brw_q);
        // After N+1 shifts the first processed bit has reached position 0.
        res_next  = {d_bit, res_q};
        diff_next = res_next[N-1:0];
`ifdef SERIAL_SUB_SAT_EN
        if (b_next) begin
            diff_next = '0;
        end else if (res_next[N]) begin
            diff_next = '1;
        end
`endif
    end

    assign ready = (state_q == StIdle);

    // Handshake FSM, datapath and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            min_q   <= '0;
            sub_q   <= '0;
            res_q   <= '0;
            brw_q   <= 1'b0;
            cnt_q   <= '0;
            done    <= 1'b0;
            diff    <= '0;
            borrow  <= 1'b0;
            ovf     <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        min_q   <= sum;
                        sub_q   <= {1'b0, addend};
                        res_q   <= '0;
                        brw_q   <= 1'b0;
                        cnt_q   <= '0;
                        state_q <= StRun;
                    end
                end
                StRun: begin
                    min_q <= min_q >> 1;
                    sub_q <= sub_q >> 1;
                    res_q <= res_next[N:1];
                    brw_q <= b_next;
                    if (cnt_q == LastBit) begin
                        state_q <= StDone;
                        done    <= 1'b1;
                        diff    <= diff_next;
                        borrow  <= b_next;
                        ovf     <= ~b_next & res_next[N];
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

`ifndef SYNTHESIS
    // done is registered together with the DONE state, so the two always coincide.
    done_in_done_state: assert property (@(posedge clk) disable iff (!rst_n)
        done |-> (state_q == StDone));
    borrow_ovf_exclusive: assert property (@(posedge clk) disable iff (!rst_n)
        !(borrow && ovf));
`endif

endmodule

// File: tb/tb_serial_sub_unit.sv
module tb_serial_sub_unit;

    localparam int unsigned N = 3;
    localparam int Lat = int'(N) + 2;  // issue negedge to done-visible negedge

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b1;
    logic [N:0]   sum = '0;
    logic [N-1:0] addend = '0;
    logic         ready;
    logic         done;
    logic [N-1:0] diff;
    logic         borrow;
    logic         ovf;

    serial_sub_unit #(.N(N)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .sum    (sum),
        .addend (addend),
        .ready  (ready),
        .done   (done),
        .diff   (diff),
        .borrow (borrow),
        .ovf    (ovf)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] s;
        logic [2:0] a;
        logic [2:0] d_raw;
        logic [2:0] d_sat;
        logic       b;
        logic       o;
    } vec_t;

    typedef struct {
        logic [N-1:0] diff;
        logic         b;
        logic         o;
        int           due;
    } exp_t;

    exp_t sb[$];
    int total = 0;
    int bad = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Hand-computed vectors: sum, addend, raw diff, saturated diff, borrow, ovf.
    function automatic vec_t get_vec(input int i);
        case (i)
            0: return '{4'b1010, 3'b011, 3'b111, 3'b111, 1'b0, 1'b0};  // 10-3=7
            1: return '{4'b1100, 3'b010, 3'b010, 3'b111, 1'b0, 1'b1};  // 12-2=10
            2: return '{4'b0010, 3'b101, 3'b101, 3'b000, 1'b1, 1'b0};  // 2-5 -> 13
            3: return '{4'b1111, 3'b111, 3'b000, 3'b111, 1'b0, 1'b1};  // 15-7=8
            4: return '{4'b0101, 3'b001, 3'b100, 3'b100, 1'b0, 1'b0};  // 5-1=4
            5: return '{4'b0000, 3'b001, 3'b111, 3'b000, 1'b1, 1'b0};  // 0-1 -> 15
            6: return '{4'b1001, 3'b110, 3'b011, 3'b011, 1'b0, 1'b0};  // 9-6=3
            7: return '{4'b0111, 3'b000, 3'b111, 3'b111, 1'b0, 1'b0};  // 7-0=7
            8: return '{4'b1111, 3'b000, 3'b111, 3'b111, 1'b0, 1'b1};  // aborted by reset
            default: return '0;
        endcase
    endfunction

    function automatic logic [N-1:0] pick_diff(input vec_t v);
`ifdef SERIAL_SUB_SAT_EN
        return v.d_sat;
`else
        return v.d_raw;
`endif
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_exp(input vec_t v);
        exp_t e;
        e.diff = pick_diff(v);
        e.b    = v.b;
        e.o    = v.o;
        e.due  = cyc + Lat;
        sb.push_back(e);
    endtask

    // Present one vector for a single cycle; the DUT is expected to be idle.
    task automatic issue(input int i);
        vec_t v;
        v = get_vec(i);
        @(negedge clk);
        start  = 1'b1;
        sum    = v.s;
        addend = v.a;
        push_exp(v);
        @(negedge clk);
        start = 1'b0;
    endtask

    // Monitor: every done must match the head of the scoreboard at its due cycle.
    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0 && cyc == sb[0].due) begin
            e = sb.pop_front();
            chk("done_pulse", done, 1);
            if (done === 1'b1) begin
                chk("diff", diff, e.diff);
                chk("borrow", borrow, e.b);
                chk("ovf", ovf, e.o);
            end
        end else if (done !== 1'b0) begin
            total++;
            bad++;
            $display("FAIL unexpected_done: got done=%b expected 0 (cycle %0d)", done, cyc);
        end
    end

    initial begin
        vec_t v;
        logic [31:0] r;

        // Reset held two cycles with start high.
        rst_n  = 1'b0;
        start  = 1'b1;
        sum    = 4'b1111;
        addend = 3'b001;
        repeat (2) @(negedge clk);
        chk("rst_ready", ready, 1);
        chk("rst_done", done, 0);
        chk("rst_diff", diff, 0);
        chk("rst_borrow", borrow, 0);
        chk("rst_ovf", ovf, 0);
        rst_n = 1'b1;
        start = 1'b0;
        repeat (10) @(negedge clk);
        chk("idle_ready", ready, 1);

        // Nominal, then hold check.
        issue(0);
        chk("ready_busy", ready, 0);
        repeat (Lat) @(negedge clk);
        chk("ready_back", ready, 1);
        repeat (3) @(negedge clk);
        chk("hold_diff", diff, 3'b111);
        chk("hold_borrow", borrow, 0);
        chk("hold_ovf", ovf, 0);

        // Overflow and underflow.
        issue(1);
        repeat (Lat) @(negedge clk);
        issue(2);
        repeat (Lat) @(negedge clk);

        // start held high with changing operands: accepts at k = 0, 6, 12, 18.
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            start = 1'b1;
            if (k % 6 == 0) begin
                v      = get_vec(4 + k / 6);
                sum    = v.s;
                addend = v.a;
                push_exp(v);
            end else begin
                r      = $urandom;
                sum    = r[N:0];
                addend = r[N+4:5];
            end
            if (k == 3) chk("hs_ready_busy", ready, 0);
            if (k == 6) chk("hs_ready_idle", ready, 1);
        end
        @(negedge clk);
        start = 1'b0;
        repeat (Lat + 2) @(negedge clk);
        chk("pre_abort_diff", diff, 3'b111);

        // Reset at the second RUN edge aborts the operation.
        v = get_vec(8);
        @(negedge clk);
        start  = 1'b1;
        sum    = v.s;
        addend = v.a;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("abort_ready", ready, 1);
        chk("abort_diff", diff, 0);
        chk("abort_borrow", borrow, 0);
        chk("abort_ovf", ovf, 0);
        repeat (6) @(negedge clk);

        // Fresh operation after the abort.
        issue(3);
        repeat (Lat + 2) @(negedge clk);

        chk("sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached (cycle %0d)", cyc);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/serial_sub_unit.md
# serial_sub_unit

Bit-serial, parameterized subtractor that recovers one operand of an N-bit addition from the (N+1)-bit sum and the other operand. It computes diff = sum − addend one bit per clock, LSB first, behind a start/ready/done handshake. It sits beside the combinational N-bit adders as their inverse/check path, trading latency for a single full-subtractor cell.

## Interface

**Parameters**
- N, default 3: operand width. The sum input is N+1 bits. Legal range is N ≥ 1.

**Ports**
- clk, input, 1: single clock. All state changes on the rising edge.
- rst_n, input, 1: synchronous, active-low reset, sampled on the rising edge of clk.
- start, input, 1: request a subtraction. Sampled only while ready=1.
- sum, input, N+1: minuend. Captured on the accepted start edge.
- addend, input, N: subtrahend, zero-extended to N+1 bits. Captured on the accepted start edge.
- ready, output, 1: high in IDLE only.
- done, output, 1: one-cycle pulse when diff, borrow and ovf are updated.
- diff, output, N: result, low N bits of the (N+1)-bit difference.
- borrow, output, 1: final borrow out of bit N. Set means sum < addend.
- ovf, output, 1: borrow=0 and bit N of the difference is 1, i.e. the true result ≥ 2^N and does not fit in N bits.

## Operation

- **States:**
  - IDLE: ready=1.
  - RUN: ready=0. Processes one bit per cycle. Bit counter runs 0..N.
  - DONE: ready=0, done=1. Lasts exactly 1 cycle.
- **Transitions:**
  - IDLE → RUN on start=1. The same edge latches sum and zero-extended addend into shift registers, clears the borrow flop and sets the counter to 0.
  - RUN → RUN while counter < N.
  - RUN → DONE on the edge that processes bit N.
  - DONE → IDLE unconditionally.
- **Per RUN edge:**
  - d_i = s_i ^ a_i ^ b
  - b' = (~s_i & a_i) | (~(s_i ^ a_i) & b)
  - d_i shifts into the result register MSB-first so that after N+1 shifts bit 0 is in position 0. b' is stored. Both operand registers shift right by 1.
- **On the RUN → DONE edge:**
  - diff ← result bits [N-1:0]
  - borrow ← final b'
  - ovf ← ~b' & result bit N
- Arithmetic is modulo 2^(N+1) and no wider state exists. Example: with borrow=1, diff equals the low N bits of (sum − addend + 2^(N+1)).
- **start outside IDLE:** ignored, including in DONE. Operands changing outside the accepting edge have no effect.
- **Back-to-back:** start held high continuously gives a new acceptance on the first IDLE cycle. Throughput is one result per N+3 cycles.
- **Output hold:** diff, borrow and ovf hold their last values until the next DONE edge or reset.

## Timing

- **Reset (rst_n=0 at an edge):**
  - state=IDLE, so ready=1.
  - done=0, diff=0, borrow=0, ovf=0.
  - Counter, shift registers and borrow flop are cleared.
- Reset overrides everything, including start on the same edge.
- Reset mid-RUN or in DONE aborts the operation. No done pulse is produced and outputs take their reset values.
- **Latency:** start accepted at edge E0. Bits 0..N are processed at edges E1..E(N+1). done=1 and the new outputs are visible in the cycle after E(N+1). ready returns 1 after E(N+2).
- For N=3: done is high in the 4th cycle after the accept edge, and ready is back in the 5th.
- done is high for exactly one cycle per accepted start.

## Configuration

- **SERIAL_SUB_SAT_EN:**
  - Defined: diff saturates on the DONE edge. If borrow=1, diff=0. If ovf=1, diff=all ones (2^N − 1). borrow and ovf still report the condition.
  - Undefined: diff is the raw wrapped low N bits as described in Operation.
- Latency and handshake are identical in both builds.

## Test plan

- **Reset and idle:** N=3, hold rst_n=0 for 2 cycles with start=1 → ready=1, done=0, diff=000, borrow=0, ovf=0. Release with start=0 → no done for 10 cycles.
- **Nominal:** sum=4'b1010, addend=3'b011, 1-cycle start → done exactly 4 cycles after the accept edge with diff=3'b111, borrow=0, ovf=0. Outputs hold afterwards.
- **Overflow:** sum=4'b1100, addend=3'b010 → diff=3'b010, ovf=1, borrow=0. With SERIAL_SUB_SAT_EN → diff=3'b111, ovf=1.
- **Underflow:** sum=4'b0010, addend=3'b101 → borrow=1, ovf=0, diff=3'b101. With SERIAL_SUB_SAT_EN → diff=3'b000.
- **Handshake:** start held high for 20 cycles with changing operands → one accept every 6 cycles (IDLE, RUN×4, DONE). Each result matches the operands present at its accept edge. Operand changes during RUN are ignored.
- **Reset mid-operation:** assert rst_n=0 at the 2nd RUN edge → no done pulse, outputs return to 0, ready=1 next cycle. A new start then completes normally: sum=4'b1111, addend=3'b111 → diff=3'b000, ovf=1.
